// File: rtl/line_fetch_if.sv
// Read port between the line fetcher and external pixel memory.
// The fetcher drives rd_en/addr; memory answers with ready and, MEM_LAT cycles later, rdata.
interface line_fetch_if #(
    parameter int ADDR_W = 17
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [7:0]        mem_rdata;

    modport master (output mem_rd_en, output mem_addr, input mem_ready, input mem_rdata);
    modport slave  (input mem_rd_en, input mem_addr, output mem_ready, output mem_rdata);
endinterface

// File: rtl/line_fetch.sv
// Double-buffered 2x-scaled line fetcher feeding the VGA pixel path; pixel is 1 cycle after (x,y).
// mem_ready low holds the current read; a row not complete by its swap point sets sticky underrun.
module line_fetch #(
    parameter int SRC_W   = 320,
    parameter int SRC_H   = 240,
    parameter int H_ACT   = 640,
    parameter int H_TOTAL = 800,
    parameter int V_ACT   = 480,
    parameter int V_TOTAL = 525,
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [9:0]   x,
    input  logic [9:0]   y,
    output logic [7:0]   pixel,
    line_fetch_if.master mem,
    output logic         underrun
);
    localparam int CW = $clog2(SRC_W);
    localparam int NW = $clog2(SRC_W + 1);

    localparam logic [9:0]        X_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0]        Y_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0]        X_ACT       = 10'(H_ACT);
    localparam logic [9:0]        Y_ACT       = 10'(V_ACT);
    localparam logic [9:0]        Y_FETCH_END = 10'(V_ACT - 1);
    localparam logic [NW-1:0]     N_ROW       = NW'(SRC_W);
    localparam logic [NW-1:0]     N_LAST      = NW'(SRC_W - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE  = ADDR_W'(SRC_W);
    localparam logic [ADDR_W-1:0] LAST_BASE   = ADDR_W'((SRC_H - 1) * SRC_W);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_nxt;

    logic [7:0]         bank0 [SRC_W];
    logic [7:0]         bank1 [SRC_W];
    logic               disp_bank;
    logic               done;
    logic               swap_due;
    logic [NW-1:0]      issue_cnt;
    logic [NW-1:0]      wr_cnt;
    logic [ADDR_W-1:0]  base;
    logic [MEM_LAT-1:0] ret_vld;

    logic          row0;
    logic          trig;
    logic          accept;
    logic          ret_hit;
    logic          active;
    logic          swap_pt;
    logic [CW-1:0] col;

    assign row0    = (y == Y_LAST);
    assign trig    = (x == '0) && (state == IDLE) && (row0 || (y[0] && (y < Y_FETCH_END)));
    assign accept  = (state == ISSUE) && mem.mem_ready;
    assign ret_hit = ret_vld[MEM_LAT-1];
    assign active  = (x < X_ACT) && (y < Y_ACT);
    assign swap_pt = (x == X_LAST) && swap_due;
    assign col     = CW'(x >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trig) state_nxt = ISSUE;
            ISSUE:   if (accept && (issue_cnt == N_LAST)) state_nxt = DRAIN;
            DRAIN:   if (wr_cnt == N_ROW) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem.mem_rd_en = (state == ISSUE);
        mem.mem_addr  = (state == ISSUE) ? base + ADDR_W'(issue_cnt) : '0;
    end

    // Running row base; a wrap guard keeps the address inside the image if triggers ever overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            wr_cnt    <= '0;
            base      <= '0;
            ret_vld   <= '0;
        end else begin
            ret_vld <= (ret_vld << 1) | MEM_LAT'(accept);
            if (trig) begin
                issue_cnt <= '0;
                wr_cnt    <= '0;
                base      <= (row0 || (base == LAST_BASE)) ? '0 : base + ROW_STRIDE;
            end else begin
                if (accept)  issue_cnt <= issue_cnt + 1'b1;
                if (ret_hit) wr_cnt    <= wr_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_bank <= 1'b0;
            done      <= 1'b0;
            swap_due  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (trig) begin
                done     <= 1'b0;
                swap_due <= 1'b1;
            end else if ((state == DRAIN) && (wr_cnt == N_ROW)) begin
                done <= 1'b1;
            end
            // A late row keeps swap_due set so the swap lands at the first line end after done.
            if (swap_pt) begin
                if (done) begin
                    disp_bank <= ~disp_bank;
                    done      <= 1'b0;
                    swap_due  <= 1'b0;
                end else begin
                    underrun <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ret_hit) begin
            if (disp_bank) bank0[CW'(wr_cnt)] <= mem.mem_rdata;
            else           bank1[CW'(wr_cnt)] <= mem.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pixel <= '0;
        else if (active) pixel <= disp_bank ? bank1[col] : bank0[col];
        else             pixel <= '0;
    end
endmodule

// File: tb/tb_line_fetch.sv
// Bench for line_fetch: twin DUTs (MEM_LAT 2 and 4) on a reduced frame, checked against a row/column pixel model.
module tb_line_fetch;
    localparam int SW = 16, SH = 12, HA = 32, HT = 48, VA = 24, VT = 28, AW = 17;
    localparam int LAT0 = 2, LAT1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [9:0]    x, y;
    logic          mem_ready;
    logic [7:0]    pix0, pix1;
    logic          und0, und1;
    logic [7:0]    rdata0 = 8'hA5, rdata1 = 8'hA5;

    line_fetch_if #(.ADDR_W(AW)) mif0 ();
    line_fetch_if #(.ADDR_W(AW)) mif1 ();
    assign mif0.mem_ready = mem_ready;
    assign mif1.mem_ready = mem_ready;
    assign mif0.mem_rdata = rdata0;
    assign mif1.mem_rdata = rdata1;

    line_fetch #(.SRC_W(SW), .SRC_H(SH), .H_ACT(HA), .H_TOTAL(HT), .V_ACT(VA), .V_TOTAL(VT),
                 .MEM_LAT(LAT0), .ADDR_W(AW)) dut0 (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .pixel(pix0), .mem(mif0), .underrun(und0));
    line_fetch #(.SRC_W(SW), .SRC_H(SH), .H_ACT(HA), .H_TOTAL(HT), .V_ACT(VA), .V_TOTAL(VT),
                 .MEM_LAT(LAT1), .ADDR_W(AW)) dut1 (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .pixel(pix1), .mem(mif1), .underrun(und1));

    int n_chk = 0, n_fail = 0;
    int phase = 0;
    bit chk_on = 0, pix_en = 1, stall_frame = 0, und_exp = 0;
    bit rst_done = 0;
    int rst_hold = 0;
    int n_acc0 = 0;
    int px = 0, py = 0;
    logic          hv [2][8];
    logic [AW-1:0] ha [2][8];
    int            exp_addr [2];
    bit            prev_stall [2];
    logic [AW-1:0] prev_addr [2];

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d (y=%0d x=%0d t=%0t)", name, d, act, exp, y, x, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_pixel", 0, pix0, 0);
        check("rst_pixel", 1, pix1, 0);
        check("rst_rd_en", 0, mif0.mem_rd_en, 0);
        check("rst_rd_en", 1, mif1.mem_rd_en, 0);
        check("rst_addr", 0, mif0.mem_addr, 0);
        check("rst_addr", 1, mif1.mem_addr, 0);
        check("rst_underrun", 0, und0, 0);
        check("rst_underrun", 1, und1, 0);
    endtask

    // Source row shown on display line yy: row yy/2, except the stalled frame repeats row 0 on line 2.
    function automatic int row_of(input int yy);
        if (stall_frame && yy == 2) return 0;
        return yy / 2;
    endfunction

    function automatic logic [7:0] exp_pixel(input int xx, input int yy);
        if (xx >= HA || yy >= VA) return 8'h00;
        return 8'((row_of(yy) * SW + xx / 2) & 255);
    endfunction

    function automatic int fetch_row(input int yy);
        if (yy == VT - 1) return 0;
        if ((yy % 2 == 1) && (yy < VA - 1)) return (yy + 1) / 2;
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [7:0]    p [2];
        logic          u [2];
        logic          re [2];
        logic [AW-1:0] ad [2];
        int            lat [2];
        logic [7:0]    rdval;
        bit            acc;
        p[0] = pix0; p[1] = pix1;
        u[0] = und0; u[1] = und1;
        re[0] = mif0.mem_rd_en; re[1] = mif1.mem_rd_en;
        ad[0] = mif0.mem_addr;  ad[1] = mif1.mem_addr;
        lat[0] = LAT0; lat[1] = LAT1;

        if (chk_on) begin
            und_exp = und_exp | (stall_frame && py == 1 && px == HT - 1);
            if (!rst_n) und_exp = 0;
        end
        for (int d = 0; d < 2; d++) begin
            acc = re[d] && mem_ready;
            if (chk_on) begin
                if (pix_en) check("pixel", d, p[d], exp_pixel(px, py));
                check("underrun", d, u[d], und_exp);
                if (y >= VA - 1 && y != VT - 1) check("idle_rd_en", d, re[d], 0);
                if (phase == 2) check("oor_rd_en", d, re[d], 0);
                if (prev_stall[d]) begin
                    check("hold_rd_en", d, re[d], 1);
                    check("hold_addr", d, ad[d], prev_addr[d]);
                end
                if (x == 0 && fetch_row(y) >= 0) exp_addr[d] = fetch_row(y) * SW;
                if (acc) begin
                    check("rd_addr", d, ad[d], exp_addr[d]);
                    exp_addr[d]++;
                end
                if (phase == 1 && py == 0 && px == 10)     check("lit_l0_x10", d, p[d], 5);
                if (phase == 1 && py == 3 && px == 0)      check("lit_l3_x0", d, p[d], 8'h10);
                if (phase == 1 && py == 0 && px == HA - 2) check("lit_last_col", d, p[d], SW - 1);
                if (phase == 2 && (px >= HT || py >= VT))  check("lit_oor", d, p[d], 0);
                if (phase == 3 && py == 5 && px == 20)     check("lit_toggle_l5", d, p[d], 42);
                if (phase == 4 && py == 2 && px == 4)      check("lit_row0_repeat", d, p[d], 2);
                if (phase == 4 && py == 3 && px == 4)      check("lit_row1_after_swap", d, p[d], 18);
                if (phase == 5 && py == 2 && px == 6)      check("lit_after_reset", d, p[d], 19);
            end
            if (d == 0) begin
                if (x == 0 && fetch_row(y) >= 0) n_acc0 = 0;
                if (acc) n_acc0++;
            end
            prev_stall[d] = re[d] && !mem_ready;
            prev_addr[d]  = ad[d];
            // Memory model: data for an accepted read appears lat cycles later; idle cycles show a filler.
            for (int i = 7; i > 0; i--) begin
                hv[d][i] = hv[d][i-1];
                ha[d][i] = ha[d][i-1];
            end
            hv[d][0] = acc;
            ha[d][0] = ad[d];
            rdval = hv[d][lat[d]] ? ha[d][lat[d]][7:0] : 8'hA5;
            if (d == 0) rdata0 = rdval;
            else        rdata1 = rdval;
        end
        px = int'(x);
        py = int'(y);
    end

    // mode 0: ready high, 1: ready toggles, 2: ready low x=5..44 of line 1, 3: ready high plus mid-fetch reset
    task automatic drive_line(input int yy, input int mode);
        for (int xx = 0; xx < HT; xx++) begin
            @(posedge clk);
            #1;
            x = 10'(xx);
            y = 10'(yy);
            case (mode)
                1:       mem_ready = (xx % 2 == 0);
                2:       mem_ready = !(yy == 1 && xx >= 5 && xx < 45);
                default: mem_ready = 1'b1;
            endcase
            if (mode == 3 && !rst_done && n_acc0 == 8) begin
                #1 rst_n = 1'b0;
                #1 check_reset_outputs();
                rst_done = 1;
                rst_hold = 3;
            end else if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end
        end
    endtask

    task automatic drive_frame(input int mode);
        for (int yy = 0; yy < VT; yy++) drive_line(yy, mode);
    endtask

    initial begin
        rst_n = 1'b0;
        x = 10'd0;
        y = 10'(VT - 2);
        mem_ready = 1'b1;
        for (int d = 0; d < 2; d++) begin
            exp_addr[d] = 0;
            prev_stall[d] = 0;
            prev_addr[d] = '0;
            for (int i = 0; i < 8; i++) begin
                hv[d][i] = 1'b0;
                ha[d][i] = '0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_on = 1;

        phase = 1;
        drive_line(VT - 1, 0);
        drive_frame(0);

        phase = 2;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            x = 10'd1000; y = 10'd0;
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            x = 10'd4; y = 10'd1000;
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            x = (i == 0) ? 10'd0 : 10'(i); y = 10'd1023;
        end

        phase = 3;
        drive_frame(1);

        phase = 4;
        stall_frame = 1;
        drive_frame(2);
        stall_frame = 0;

        phase = 5;
        drive_line(VT - 1, 3);
        check("reset_pulse_hit", 0, rst_done, 1);
        pix_en = 0;
        drive_line(0, 0);
        drive_line(1, 0);
        pix_en = 1;
        for (int yy = 2; yy < 6; yy++) drive_line(yy, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/line_fetch.md
Name: line_fetch

Overview:
- Upstream pixel source for the VGA output stage, running in the pixel-clock domain.
- Takes the scan coordinates x and y from the timing generator and returns the 8-bit pixel for that position.
- The source image is SRC_W x SRC_H bytes in external memory. It is shown 2x scaled (each source pixel covers 2x2 display pixels).
- Uses a double-buffered line buffer: one bank is displayed while the next source row is prefetched into the other.

Parameters:
SRC_W, 320, source pixels per row
SRC_H, 240, source rows
H_ACT, 640, active display columns
H_TOTAL, 800, columns per display line including blanking
V_ACT, 480, active display lines
V_TOTAL, 525, lines per frame including blanking
MEM_LAT, 2, cycles from accepted read to valid mem_rdata
ADDR_W, 17, memory address width

Ports:
clk  in  1  pixel clock (same clock as the timing generator)
rst_n  in  1  asynchronous, active-low reset
x  in  10  current scan column
y  in  10  current scan line
pixel  out  8  pixel for the (x,y) presented one cycle earlier
mem_rd_en  out  1  read request
mem_addr  out  ADDR_W  read address = row*SRC_W + col
mem_ready  in  1  memory accepts mem_rd_en this cycle
mem_rdata  in  8  read data, valid exactly MEM_LAT cycles after an accepted read
underrun  out  1  sticky: a bank swap was due but the fetch was not complete

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pixel=0, mem_rd_en=0, mem_addr=0, underrun=0.
  - disp_bank=0, FSM=IDLE, issue and write counters=0, done=0.
  - Return-valid pipeline cleared.
  - Reset mid-fetch aborts the fetch; data returning after reset is discarded.
- Storage: two banks of SRC_W x 8 bits, read index col=x>>1.
- Pixel output is registered, latency 1 cycle:
  - If x<H_ACT and y<V_ACT: pixel <= bank[disp_bank][x>>1].
  - Otherwise pixel <= 0.
- Fetch trigger, when x==0 and FSM==IDLE:
  - On line V_TOTAL-1, fetch row 0.
  - On odd line y with y<V_ACT-1, fetch row (y+1)>>1.
  - Row base is kept as a running register: cleared when row 0 is fetched, incremented by SRC_W for each later row. No multiplier.
- FSM states:
  - IDLE: on trigger, go to ISSUE. Clear done; issue_cnt=0, wr_cnt=0.
  - ISSUE: mem_rd_en=1, mem_addr=base+issue_cnt. Each cycle with mem_ready=1 counts as accepted and increments issue_cnt. After the accepted read at issue_cnt==SRC_W-1, go to DRAIN with mem_rd_en=0. While mem_ready=0, hold the address and hold mem_rd_en high.
  - DRAIN: wait until wr_cnt==SRC_W, then set done=1 and go to IDLE.
- Return path:
  - Each accepted read pushes a valid bit through a MEM_LAT-deep shift register.
  - When the valid bit emerges, write mem_rdata to bank[!disp_bank][wr_cnt] and increment wr_cnt.
  - Writes and display reads target different banks, so both happen in the same cycle with no conflict.
- Bank swap, at x==H_TOTAL-1 of a trigger line:
  - If done=1: toggle disp_bank and clear done.
  - If done=0: no swap and set underrun=1. The fetch continues; the swap happens at the first later x==H_TOTAL-1 that finds done=1.
- Rows and bank contents:
  - Row r is displayed on lines 2r and 2r+1.
  - Lines V_ACT-1 through V_TOTAL-2 issue no fetch.
  - Bank contents persist through vertical blanking.
- Timing constraint: SRC_W+MEM_LAT+1 <= H_TOTAL-1 guarantees no underrun when mem_ready is constant 1.
- Address arithmetic is unsigned ADDR_W bits. The maximum address is SRC_W*SRC_H-1 = 76799, so there is no wrap-around.
- x or y values outside their totals produce pixel=0 and never trigger a fetch.

Test Plan:
1. Reset, then a full frame with mem_ready=1 and memory model data = addr[7:0] -> row-0 fetch on line 524 issues addresses 0..319 consecutively; line 0 at x=10 gives pixel=5 one cycle later; line 3 (row 1) at x=0 gives pixel=320[7:0]=0x40.
2. Blanking: x=700 or y=490 -> pixel=0; mem_rd_en=0 throughout lines 479..523.
3. mem_ready toggling 1-0 every cycle -> mem_addr holds while stalled; all 320 bytes land in order; underrun stays 0 because 640+2 < 799.
4. mem_ready=0 for 600 cycles mid-fetch on line 1 -> underrun=1 at x=799; disp_bank unchanged on line 2 (row 0 repeated); swap at the end of line 2; underrun remains 1.
5. MEM_LAT=4 build -> data still aligned; pixel at line 0, x=638 equals mem[319].
6. rst_n pulsed low at issue_cnt=100 -> outputs return to reset values immediately; in-flight returns are not written; normal operation resumes at the next trigger.
